// File: rtl/dc_pkg.sv
// Shared definitions for the DVI capture path: pixel-word layout and the
// capture state encoding. The word layout is common to the packer (write
// side) and sync_controller (read side).
package dc_pkg;

    localparam int WORD_W  = 44;
    localparam int COORD_W = 10;
    localparam int COLOR_W = 8;

    localparam int X_MSB = 43;
    localparam int X_LSB = 34;
    localparam int Y_MSB = 33;
    localparam int Y_LSB = 24;
    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef enum logic {
        S_WAIT_VS = 1'b0,
        S_ACTIVE  = 1'b1
    } state_t;

    typedef logic [WORD_W-1:0]  pix_word_t;
    typedef logic [COORD_W-1:0] coord_t;

    // Builds a FIFO word from a raster position and an RGB triple.
    function automatic pix_word_t pack_word(
        input coord_t             x,
        input coord_t             y,
        input logic [COLOR_W-1:0] r,
        input logic [COLOR_W-1:0] g,
        input logic [COLOR_W-1:0] b
    );
        pix_word_t w;
        w              = '0;
        w[X_MSB:X_LSB] = x;
        w[Y_MSB:Y_LSB] = y;
        w[R_MSB:R_LSB] = r;
        w[G_MSB:G_LSB] = g;
        w[B_MSB:B_LSB] = b;
        return w;
    endfunction

    // Field extractors for the read side.
    function automatic coord_t word_x(input pix_word_t w);
        return w[X_MSB:X_LSB];
    endfunction

    function automatic coord_t word_y(input pix_word_t w);
        return w[Y_MSB:Y_LSB];
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position tracking for the DVI packer. Detects the frame-start
// edge on in_vs and the data-enable edges, keeps the (x, y) position of the
// current pixel and flags raster overruns. The position presented on
// x_pix/y_pix is the one the pixel on the inputs this cycle belongs to,
// with a coincident frame start already applied (that pixel is (0,0)).
module raster_counter
    import dc_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int VS_POL   = 1
) (
    input  logic   clk_25,
    input  logic   rst,
    input  logic   active,
    input  logic   enable,
    input  logic   in_de,
    input  logic   in_vs,
    output logic   fs,
    output logic   run,
    output logic   de_rise,
    output logic   h_over,
    output logic   v_over,
    output coord_t x_pix,
    output coord_t y_pix
);

    localparam coord_t H_END  = COORD_W'(H_ACTIVE);
    localparam coord_t V_END  = COORD_W'(V_ACTIVE);
    localparam coord_t ONE    = COORD_W'(1);
    localparam logic   VS_ACT = (VS_POL != 0);

    logic   de_q;
    logic   vs_q;
    coord_t x;
    coord_t y;
    coord_t x_next;
    coord_t y_next;
    logic   clear;
    logic   de_fall;

    // Frame start is the first cycle in_vs sits at its active level.
    assign fs      = (in_vs == VS_ACT) && (vs_q != VS_ACT);

    // A frame start with enable high (re)starts capture; one with enable
    // low ends it, so the pixel in that cycle is not counted.
    assign clear   = fs && enable;
    assign run     = clear || (active && !fs);

    assign de_rise = in_de && !de_q;
    assign de_fall = !in_de && de_q;

    assign x_pix   = clear ? '0 : x;
    assign y_pix   = clear ? '0 : y;

    // x pinned at H_END means the line is already too long.
    assign h_over  = run && in_de && (x_pix == H_END);
    // A new line starting once y has saturated means too many lines.
    assign v_over  = run && de_rise && (y_pix == V_END);

    // Next raster position: advance x per pixel, wrap to the next line on
    // the end of data-enable; both counters saturate at the active size.
    always_comb begin
        x_next = x;
        y_next = y;
        if (run) begin
            x_next = x_pix;
            y_next = y_pix;
            if (in_de) begin
                if (x_pix < H_END) begin
                    x_next = x_pix + ONE;
                end
            end else if (de_fall && !clear) begin
                x_next = '0;
                if (y_pix < V_END) begin
                    y_next = y_pix + ONE;
                end
            end
        end
    end

    // Edge-detect registers and position counters. vs_q resets to the
    // active level so a frame start needs a fresh inactive-to-active edge.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            de_q <= 1'b0;
            vs_q <= VS_ACT;
            x    <= '0;
            y    <= '0;
        end else begin
            de_q <= in_de;
            vs_q <= in_vs;
            x    <= x_next;
            y    <= y_next;
        end
    end

endmodule

// File: rtl/dvi_pixel_packer.sv
// DVI pixel packer: tags each active pixel with its raster position, packs
// it into a 44-bit FIFO word and writes it with a one-cycle latency.
// Handles frame alignment, optional decimation (1, 2 or 4), drops on a full
// FIFO and sticky raster/overflow status.
module dvi_pixel_packer
    import dc_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DECIM    = 1,
    parameter int VS_POL   = 1
) (
    input  logic               clk_25,
    input  logic               rst,
    input  logic               enable,
    input  logic               in_de,
    input  logic               in_vs,
    input  logic [COLOR_W-1:0] in_r,
    input  logic [COLOR_W-1:0] in_g,
    input  logic [COLOR_W-1:0] in_b,
    output logic               wrclk,
    output logic               wrreq,
    output logic [WORD_W-1:0]  data,
    input  logic               wrfull,
    input  logic               clr_status,
    output logic               overflow,
    output logic               line_err,
    output logic [15:0]        drop_cnt,
    output logic [7:0]         frame_cnt
);

    localparam coord_t H_END  = COORD_W'(H_ACTIVE);
    localparam coord_t V_END  = COORD_W'(V_ACTIVE);
    // DECIM is a power of two, so "coordinate mod DECIM" is a low-bit mask.
    localparam coord_t D_MASK = COORD_W'(DECIM - 1);

    state_t state;
    logic   fs;
    logic   run;
    logic   de_rise;
    logic   h_over;
    logic   v_over;
    coord_t x_pix;
    coord_t y_pix;
    logic   in_raster;
    logic   on_grid;
    logic   valid;
    logic   push;
    logic   drop;

    assign wrclk = clk_25;

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .VS_POL   (VS_POL)
    ) u_raster (
        .clk_25  (clk_25),
        .rst     (rst),
        .active  (state == S_ACTIVE),
        .enable  (enable),
        .in_de   (in_de),
        .in_vs   (in_vs),
        .fs      (fs),
        .run     (run),
        .de_rise (de_rise),
        .h_over  (h_over),
        .v_over  (v_over),
        .x_pix   (x_pix),
        .y_pix   (y_pix)
    );

    assign in_raster = (x_pix < H_END) && (y_pix < V_END);
    assign on_grid   = ((x_pix & D_MASK) == '0) && ((y_pix & D_MASK) == '0);
    assign valid     = run && in_de && in_raster && on_grid;
    assign push      = valid && !wrfull;
    assign drop      = valid && wrfull;

    // Capture FSM, frame counter and the registered FIFO write port.
    //   state     | meaning
    //   S_WAIT_VS | idle; waiting for a frame start with enable high
    //   S_ACTIVE  | capturing; pixels are pushed until a frame start with
    //             | enable low
    always_ff @(posedge clk_25) begin
        if (rst) begin
            state     <= S_WAIT_VS;
            frame_cnt <= '0;
            wrreq     <= 1'b0;
            data      <= '0;
        end else begin
            if (fs) begin
                if (enable) begin
                    state     <= S_ACTIVE;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    state     <= S_WAIT_VS;
                end
            end
            wrreq <= push;
            if (push) begin
                data <= pack_word(x_pix, y_pix, in_r, in_g, in_b);
            end
        end
    end

    // Sticky status; a drop or raster error in the same cycle as a clear
    // wins, so the event is never lost.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            overflow <= 1'b0;
            line_err <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (clr_status) begin
                overflow <= 1'b0;
                line_err <= 1'b0;
                drop_cnt <= '0;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (clr_status) begin
                    drop_cnt <= 16'd1;
                end else if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
            if (h_over || v_over) begin
                line_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dvi_pixel_packer.sv
// Bench for dvi_pixel_packer on a reduced raster. Two instances share the
// stimulus: one without decimation, one with DECIM=2. The expected FIFO
// contents come from the bench's knowledge of the raster it drives.
module tb_dvi_pixel_packer;

    localparam int H   = 32;
    localparam int V   = 8;
    localparam int HBL = 6;

    logic        clk_25 = 1'b0;
    logic        rst, enable, in_de, in_vs, wrfull, clr_status;
    logic [7:0]  in_r, in_g, in_b;

    logic        wrclk1, wrreq1, overflow1, line_err1;
    logic [43:0] data1;
    logic [15:0] drop_cnt1;
    logic [7:0]  frame_cnt1;
    logic        wrclk2, wrreq2, overflow2, line_err2;
    logic [43:0] data2;
    logic [15:0] drop_cnt2;
    logic [7:0]  frame_cnt2;

    always #20 clk_25 = ~clk_25;

    dvi_pixel_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .VS_POL(1)) u_dut1 (
        .clk_25(clk_25), .rst(rst), .enable(enable), .in_de(in_de), .in_vs(in_vs),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .wrclk(wrclk1), .wrreq(wrreq1),
        .data(data1), .wrfull(wrfull), .clr_status(clr_status), .overflow(overflow1),
        .line_err(line_err1), .drop_cnt(drop_cnt1), .frame_cnt(frame_cnt1));

    dvi_pixel_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(2), .VS_POL(1)) u_dut2 (
        .clk_25(clk_25), .rst(rst), .enable(enable), .in_de(in_de), .in_vs(in_vs),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .wrclk(wrclk2), .wrreq(wrreq2),
        .data(data2), .wrfull(wrfull), .clr_status(clr_status), .overflow(overflow2),
        .line_err(line_err2), .drop_cnt(drop_cnt2), .frame_cnt(frame_cnt2));

    typedef struct {
        logic [43:0] w;
        int          c;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model state
    bit cap     = 1'b0;
    bit prev_vs = 1'b1;
    bit prev_de = 1'b0;
    int fcnt    = 0;
    int drop1   = 0, drop2 = 0;
    bit ovf1    = 0, ovf2 = 0;
    bit lerr    = 0;
    int pushed1 = 0, pushed2 = 0;

    // monitor results
    int          n1 = 0, n2 = 0;
    logic [43:0] first1, last1, second2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_25) cyc++;

    // Every cycle: wrreq must be high exactly when a word is due.
    always @(negedge clk_25) begin
        bit   e1, e2;
        exp_t e;
        e1 = (q1.size() > 0) && (q1[0].c == cyc);
        e2 = (q2.size() > 0) && (q2[0].c == cyc);
        check("wrreq_d1", wrreq1, e1);
        check("wrreq_d2", wrreq2, e2);
        if (e1) begin
            e = q1.pop_front();
            if (wrreq1) begin
                check("word_d1", data1, e.w);
                if (n1 == 0) first1 = data1;
                last1 = data1;
                n1++;
            end
        end
        if (e2) begin
            e = q2.pop_front();
            if (wrreq2) begin
                check("word_d2", data2, e.w);
                if (n2 == 1) second2 = data2;
                n2++;
            end
        end
    end

    function automatic bit on_raster(input int x, input int y, input int d);
        return (x < H) && (y < V) && (x % d == 0) && (y % d == 0);
    endfunction

    // One clock of stimulus with the model updated from the spec rules.
    task automatic cycle(input bit de, input int x, input int y, input bit vs);
        exp_t e;
        in_de = de;
        in_vs = vs;
        in_r  = 8'($urandom);
        in_g  = 8'($urandom);
        in_b  = 8'($urandom);
        if (rst) begin
            cap = 0; fcnt = 0; drop1 = 0; drop2 = 0; ovf1 = 0; ovf2 = 0; lerr = 0;
            prev_vs = 1; prev_de = 0;
        end else begin
            if (vs && !prev_vs) begin
                cap = enable;
                if (enable) fcnt = (fcnt + 1) % 256;
            end
            if (clr_status) begin
                drop1 = 0; drop2 = 0; ovf1 = 0; ovf2 = 0; lerr = 0;
            end
            if (cap && de) begin
                if (x >= H) lerr = 1;
                if (!prev_de && y >= V) lerr = 1;
                e.w = {10'(x), 10'(y), in_r, in_g, in_b};
                e.c = cyc + 1;
                if (on_raster(x, y, 1)) begin
                    if (wrfull) begin drop1++; ovf1 = 1; end
                    else begin q1.push_back(e); pushed1++; end
                end
                if (on_raster(x, y, 2)) begin
                    if (wrfull) begin drop2++; ovf2 = 1; end
                    else begin q2.push_back(e); pushed2++; end
                end
            end
            prev_vs = vs;
            prev_de = de;
        end
        @(posedge clk_25);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic vsync();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        idle(2);
    endtask

    task automatic line(input int y, input int n, input int full_lo, input int full_hi,
                        input int clr_at, input bit rnd);
        for (int i = 0; i < n; i++) begin
            wrfull     = (i >= full_lo && i < full_hi) || (rnd && $urandom_range(0, 7) == 0);
            clr_status = (i == clr_at);
            cycle(1, i, y, 0);
        end
        wrfull     = 0;
        clr_status = 0;
        idle(HBL);
    endtask

    task automatic plain_frame();
        vsync();
        for (int y = 0; y < V; y++) line(y, H, 0, 0, -1, 0);
        idle(3);
    endtask

    task automatic clear_status();
        clr_status = 1;
        cycle(0, 0, 0, 0);
        clr_status = 0;
        idle(1);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_drop_d1"}, drop_cnt1, drop1);
        check({tag, "_drop_d2"}, drop_cnt2, drop2);
        check({tag, "_ovf_d1"}, overflow1, ovf1);
        check({tag, "_ovf_d2"}, overflow2, ovf2);
        check({tag, "_lerr_d1"}, line_err1, lerr);
        check({tag, "_lerr_d2"}, line_err2, lerr);
    endtask

    task automatic start_count();
        n1 = 0; n2 = 0; pushed1 = 0; pushed2 = 0;
    endtask

    task automatic end_count(input string tag);
        check({tag, "_pushes_d1"}, n1, pushed1);
        check({tag, "_pushes_d2"}, n2, pushed2);
        check({tag, "_frame_cnt_d1"}, frame_cnt1, fcnt);
        check({tag, "_frame_cnt_d2"}, frame_cnt2, fcnt);
    endtask

    initial begin
        rst = 1; enable = 0; in_de = 0; in_vs = 0; wrfull = 0; clr_status = 0;
        in_r = 0; in_g = 0; in_b = 0;
        idle(3);
        check("rst_wrreq_d1", wrreq1, 0);
        check("rst_data_d1", data1, 0);
        check("rst_data_d2", data2, 0);
        check("rst_frame_cnt_d1", frame_cnt1, 0);
        check_status("rst");
        rst = 0;
        idle(4);
        enable = 1;

        // frame 1: full raster, nothing dropped
        start_count();
        plain_frame();
        end_count("f1");
        check("f1_total_d1", n1, H * V);
        check("f1_total_d2", n2, H * V / 4);
        check("f1_frame_cnt", frame_cnt1, 1);
        check("f1_first_xy", first1[43:24], 20'd0);
        check("f1_last_xy", last1[43:24], {10'(H - 1), 10'(V - 1)});
        check("f1_second_x_d2", second2[43:34], 10'd2);
        check("f1_second_y_d2", second2[33:24], 10'd0);
        check_status("f1");

        // frame 2: FIFO full across 10 valid pixels of line 2
        start_count();
        vsync();
        for (int y = 0; y < V; y++) line(y, H, (y == 2) ? 5 : 0, (y == 2) ? 15 : 0, -1, 0);
        idle(3);
        end_count("f2");
        check("f2_drop_cnt_d1", drop_cnt1, 10);
        check("f2_drop_cnt_d2", drop_cnt2, 5);
        check_status("f2");
        clear_status();
        check("f2_clr_drop_d1", drop_cnt1, 0);
        check("f2_clr_ovf_d1", overflow1, 0);
        check_status("f2_clr");

        // frame 3: clear colliding with a drop, over-long line, extra line
        start_count();
        vsync();
        line(0, H, 0, 4, -1, 0);
        check_status("f3_l0");
        line(1, H + 2, 0, 1, 0, 0);
        check("f3_l1_drop_d1", drop_cnt1, 1);
        check("f3_l1_lerr_d1", line_err1, 1);
        check_status("f3_l1");
        clear_status();
        check_status("f3_clr");
        for (int y = 2; y < V; y++) line(y, H, 0, 0, -1, 0);
        line(V, H, 0, 0, -1, 0);
        check("f3_vover_lerr_d1", line_err1, 1);
        check_status("f3_vover");
        end_count("f3");
        clear_status();

        // frame 4: random FIFO back-pressure
        start_count();
        vsync();
        for (int y = 0; y < V; y++) line(y, H, 0, 0, -1, 1);
        idle(3);
        end_count("f4");
        check_status("f4");
        clear_status();

        // frame 5 loses enable mid-frame but completes; frame 6 is skipped
        start_count();
        vsync();
        for (int y = 0; y < V; y++) begin
            if (y == 4) enable = 0;
            line(y, H, 0, 0, -1, 0);
        end
        idle(3);
        end_count("f5");
        check("f5_total_d1", n1, H * V);
        start_count();
        plain_frame();
        end_count("f6");
        check("f6_no_push_d1", n1, 0);
        check("f6_frame_cnt_hold", frame_cnt1, 5);
        enable = 1;
        start_count();
        plain_frame();
        end_count("f7");
        check("f7_total_d1", n1, H * V);

        // frame 8: reset in the middle of line 5
        start_count();
        vsync();
        for (int y = 0; y < 5; y++) line(y, H, 0, 0, -1, 0);
        for (int i = 0; i < 10; i++) cycle(1, i, 5, 0);
        rst = 1;
        cycle(1, 10, 5, 0);
        rst = 0;
        check("rst_mid_wrreq_d1", wrreq1, 0);
        check("rst_mid_wrreq_d2", wrreq2, 0);
        check("rst_mid_frame_cnt", frame_cnt1, 0);
        for (int i = 11; i < H; i++) cycle(1, i, 5, 0);
        idle(HBL);
        for (int y = 6; y < V; y++) line(y, H, 0, 0, -1, 0);
        idle(3);
        check_status("f8");

        // frame 9: capture restarts from a fresh frame start
        start_count();
        plain_frame();
        end_count("f9");
        check("f9_total_d1", n1, H * V);
        check("f9_frame_cnt", frame_cnt1, 1);
        check("f9_first_xy", first1[43:24], 20'd0);

        idle(4);
        check("queue_empty_d1", q1.size(), 0);
        check("queue_empty_d2", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dvi_pixel_packer.md
Name: dvi_pixel_packer

Overview:
- Upstream feeder of the pixel FIFO that sync_controller drains.
- Timestamps each active DVI pixel with its (x, y) raster position, packs it into the 44-bit FIFO word and issues write requests.
- Handles frame alignment, optional decimation, FIFO-full drops and raster error reporting.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- DECIM, 1, spatial decimation; legal values are 1, 2 and 4. A pixel is pushed only when x%DECIM==0 and y%DECIM==0.
- VS_POL, 1, active level of in_vs.

Ports:
- clk_25  in  1  pixel clock; the FIFO write side also runs on it.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  capture enable; sampled only at frame start.
- in_de  in  1  DVI data-enable.
- in_vs  in  1  DVI vertical sync.
- in_r  in  8  red.
- in_g  in  8  green.
- in_b  in  8  blue.
- wrclk  out  1  tied to clk_25.
- wrreq  out  1  FIFO write strobe, one cycle per pushed pixel.
- data  out  44  packed word {x[9:0], y[9:0], r[7:0], g[7:0], b[7:0]}: bits 43:34 = x, 33:24 = y, 23:16 = r, 15:8 = g, 7:0 = b.
- wrfull  in  1  FIFO full.
- clr_status  in  1  clears the sticky flags and drop_cnt.
- overflow  out  1  sticky: at least one pixel was dropped because wrfull was high.
- line_err  out  1  sticky: raster exceeded H_ACTIVE or V_ACTIVE.
- drop_cnt  out  16  saturating count of dropped pixels.
- frame_cnt  out  8  captured frames, wraps at 255.

Behaviour:
- One clock (clk_25); reset is synchronous and active-high (rst). All state changes occur on the clk_25 rising edge.
- Reset values: wrreq=0, data=0, overflow=0, line_err=0, drop_cnt=0, frame_cnt=0, x=y=0, state=S_WAIT_VS.
- Frame-start event (fs): the cycle in which in_vs reaches VS_POL after being at the opposite level. Detection uses a registered copy of in_vs.
- State machine:
  - S_WAIT_VS → S_ACTIVE on fs when enable=1. x and y clear to 0. frame_cnt increments on the same edge.
  - S_ACTIVE → S_WAIT_VS on fs when enable=0. Pixels of the current frame are still pushed up to that fs.
  - S_ACTIVE stays in S_ACTIVE on fs when enable=1. x and y clear to 0 and frame_cnt increments.
  - A mid-frame drop of enable has no effect until the next fs.
- Counters, in S_ACTIVE only:
  - Each cycle with in_de=1, the pixel uses the current (x, y); then x increments.
  - On the in_de falling edge (registered de=1, in_de=0): x←0, y←y+1.
  - y saturates at V_ACTIVE.
- Valid pixel: state==S_ACTIVE, in_de=1, x<H_ACTIVE, y<V_ACTIVE, and both decimation conditions true.
- Push: a valid pixel with wrfull=0 produces wrreq=1 and data={x, y, in_r, in_g, in_b} on the next edge.
  - Latency is exactly 1 cycle.
  - data holds its last value when wrreq=0.
- Drop: a valid pixel with wrfull=1 produces wrreq=0, sets overflow and increments drop_cnt, saturating at 16'hFFFF. No retry.
- Raster error:
  - in_de=1 with x==H_ACTIVE: sets line_err. The pixel is not pushed and x holds at H_ACTIVE until de falls.
  - A de rising edge with y==V_ACTIVE: sets line_err. Nothing is pushed until the next fs.
- clr_status=1: clears overflow, line_err and drop_cnt on that edge. A drop or error event in the same cycle takes precedence, so the flag ends set and drop_cnt ends at 1.
- In S_WAIT_VS: no pushes, no counting, no flag updates.
- fs coinciding with in_de=1: the counter clear applies first, so that pixel is treated as (0,0).
- rst mid-line: any pending wrreq is cancelled on that edge, and the block waits for a fresh fs.

Decomposition:
- Shared package (dc_pkg):
  - pixel-word field offsets, i.e. the X/Y/R/G/B bit ranges, also used by sync_controller;
  - the 44-bit word width;
  - state encodings S_WAIT_VS and S_ACTIVE.
- One natural sub-module: raster_counter (edge detection on in_de/in_vs, x/y counters, fs pulse, overrun flags). The packer adds push/drop logic and status.

Test Plan:
- Reset, then enable=1, one fs, a 640×480 raster, wrfull=0, DECIM=1:
  - exactly 307200 wrreq;
  - first word x=0, y=0; last word x=639, y=479;
  - RGB matches the stimulus; frame_cnt=1.
- DECIM=2 on the same raster: 76800 pushes; the second word has x=2, y=0; no word with an odd x or y appears.
- Hold wrfull=1 for 10 valid pixels mid-line: those 10 are absent from the FIFO, drop_cnt=10, overflow=1. clr_status then gives 0/0.
- Drive a line with de high for 642 cycles: 640 pushes, line_err=1, and the next line starts at x=0, y+1.
- Pulse enable=0 mid-frame 1: frame 1 completes normally; frame 2 produces zero wrreq and frame_cnt stays 1. Re-enabling resumes capture at the following fs.
- Assert rst during pixel x=100 of line 5: wrreq=0 on the next edge and no pushes occur until a new fs. After that fs, capture restarts at (0,0) and frame_cnt=1 for the next captured frame.
